sample_unpacker: RTL and testbench

- Splits 32-bit audio samples into a little-endian byte stream. This is the reverse of the byte-to-sample assembler.
- Sits on the return path: I2S-capture side to the 8-bit USB FIFO side.
- Accepts one sample per valid/ready handshake and emits 1, 2 or 4 bytes, depending on the sample-size code latched with that sample.

---
 rtl/sample_unpacker.sv | 104 ++++++++++
 tb/tb_sample_unpacker.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sample_unpacker.sv
// Splits a 32-bit right-justified audio sample into a little-endian byte stream
// of 1, 2 or 4 bytes, selected by the size code latched at accept.
module sample_unpacker #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [2:0]        sample_size,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              last_byte,
  output logic              busy,
  output logic              size_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]        state;
  logic [DATA_W-1:0] held;
  logic [1:0]        count_m1;
  logic [1:0]        counter;
  logic [1:0]        next_cnt;
  logic              accept;
  logic              xfer;
  logic              code_ok;
  logic [1:0]        new_m1;
  logic [DATA_W-1:0] new_word;

  // Unused upper bits are zeroed at latch time so byte selection is a plain slice.
  always_comb begin
    code_ok  = 1'b1;
    new_m1   = 2'd0;
    new_word = sample_in;
    case (sample_size)
      3'd0: begin
        new_m1   = 2'd0;
        new_word = {{(DATA_W-8){1'b0}}, sample_in[7:0]};
      end
      3'd1: begin
        new_m1   = 2'd1;
        new_word = {{(DATA_W-12){1'b0}}, sample_in[11:0]};
      end
      3'd3: begin
        new_m1   = 2'd1;
        new_word = {{(DATA_W-16){1'b0}}, sample_in[15:0]};
      end
      3'd4: begin
        new_m1   = 2'd3;
        new_word = sample_in;
      end
      default: code_ok = 1'b0;
    endcase
  end

  assign sample_ready = !byte_valid || (byte_ready && last_byte);
  assign accept       = sample_valid && sample_ready;
  assign xfer         = byte_valid && byte_ready;
  assign next_cnt     = counter + 2'd1;
  assign busy         = (state == S_SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      held       <= '0;
      count_m1   <= 2'd0;
      counter    <= 2'd0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      last_byte  <= 1'b0;
      size_err   <= 1'b0;
    end else begin
      size_err <= accept && !code_ok;
      // A valid accept can only coincide with the last-byte transfer, so reload wins.
      if (accept && code_ok) begin
        state      <= S_SEND;
        held       <= new_word;
        count_m1   <= new_m1;
        counter    <= 2'd0;
        byte_valid <= 1'b1;
        byte_out   <= new_word[BYTE_W-1:0];
        last_byte  <= (new_m1 == 2'd0);
      end else if (xfer) begin
        if (last_byte) begin
          state      <= S_IDLE;
          counter    <= 2'd0;
          byte_valid <= 1'b0;
          byte_out   <= '0;
          last_byte  <= 1'b0;
        end else begin
          counter   <= next_cnt;
          byte_out  <= held[{next_cnt, 3'b000} +: BYTE_W];
          last_byte <= (next_cnt == count_m1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_unpacker.sv
// Randomized and directed bench for sample_unpacker, checked against a queue
// of expected bytes built from the size-code rules.
module tb_sample_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sample_in;
  logic [2:0]  sample_size;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        last_byte;
  logic        busy;
  logic        size_err;

  sample_unpacker dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_size  (sample_size),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .last_byte    (last_byte),
    .busy         (busy),
    .size_err     (size_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] q[$];
  logic       err_exp  = 1'b0;
  logic       post_rst = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit code_valid(input logic [2:0] sz);
    return (sz == 3'd0) || (sz == 3'd1) || (sz == 3'd3) || (sz == 3'd4);
  endfunction

  task automatic push_sample(input logic [2:0] sz, input logic [31:0] sd);
    int          n;
    logic [31:0] v;
    n = (sz == 3'd0) ? 1 : (sz == 3'd4) ? 4 : 2;
    v = (sz == 3'd1) ? (sd % 32'd4096) : sd;
    for (int i = 0; i < n; i++) q.push_back(8'((v >> (8 * i)) & 32'hFF));
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input logic r, input logic sv, input logic [2:0] sz,
                       input logic [31:0] sd, input logic br);
    bit exp_valid, exp_ready, acc, xf;
    rst = r; sample_valid = sv; sample_size = sz; sample_in = sd; byte_ready = br;
    #2;
    exp_valid = (q.size() > 0);
    check("byte_valid", byte_valid, exp_valid);
    check("busy", busy, exp_valid);
    check("size_err", size_err, err_exp);
    if (exp_valid) begin
      check("byte_out", byte_out, q[0]);
      check("last_byte", last_byte, q.size() == 1);
    end else begin
      check("last_byte_idle", last_byte, 0);
      if (post_rst) check("byte_out_rst", byte_out, 0);
    end
    exp_ready = !exp_valid || (br && q.size() == 1);
    check("sample_ready", sample_ready, exp_ready);
    acc = !r && sv && exp_ready;
    xf  = !r && exp_valid && br;
    @(posedge clk);
    #1;
    post_rst = r;
    err_exp  = 1'b0;
    if (r) q.delete();
    else begin
      if (xf) void'(q.pop_front());
      if (acc) begin
        if (code_valid(sz)) push_sample(sz, sd);
        else err_exp = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_size = 3'd0; sample_in = '0; byte_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    post_rst = 1'b1;

    // reset in the middle of a 32-bit sample
    cycle(0, 1, 3'd4, 32'hCAFE_F00D, 1);
    cycle(0, 0, 3'd0, 32'h0, 1);
    cycle(0, 0, 3'd0, 32'h0, 0);
    cycle(1, 0, 3'd0, 32'h0, 1);
    cycle(1, 0, 3'd0, 32'h0, 1);
    cycle(0, 1, 3'd4, 32'h0102_0304, 1);
    repeat (5) cycle(0, 0, 3'd0, 32'h0, 1);

    // 12-bit
    cycle(0, 1, 3'd1, 32'hDEAD_BAAA, 1);
    repeat (3) cycle(0, 0, 3'd1, 32'h0, 1);

    // 32-bit with alternating backpressure, next sample waiting
    cycle(0, 1, 3'd4, 32'h1122_3344, 1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 3'd0, 32'h5566_7788, (i % 2) == 0);
    repeat (2) cycle(0, 0, 3'd0, 32'h0, 1);

    // back-to-back 8-bit
    cycle(0, 1, 3'd0, 32'h0000_00AA, 1);
    cycle(0, 1, 3'd0, 32'h0000_00FF, 1);
    repeat (2) cycle(0, 0, 3'd0, 32'h0, 1);

    // 16-bit, size input changes mid-emission
    cycle(0, 1, 3'd3, 32'h0000_BEEF, 1);
    repeat (3) cycle(0, 0, 3'd4, 32'h0, 1);

    // reserved code then normal sample
    cycle(0, 1, 3'd2, 32'h0000_1234, 1);
    cycle(0, 0, 3'd0, 32'h0, 1);
    cycle(0, 1, 3'd0, 32'h0000_0055, 1);
    repeat (2) cycle(0, 0, 3'd0, 32'h0, 1);

    for (int i = 0; i < 800; i++)
      cycle(($urandom % 97) == 0, ($urandom % 3) != 0, 3'($urandom % 8),
            $urandom, ($urandom % 4) != 0);
    repeat (6) cycle(0, 0, 3'd0, 32'h0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
